prga_fifo_ext: RTL and testbench

Parametrised synchronous FIFO generalising the basic PRGA FIFO: configurable depth, selectable lookahead (first-word-fall-through) or registered-read mode, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the drop-in queue for PRGA fabric-side and system-side buffering. Lookahead conversion buffers become unnecessary wherever it is used.

---
 rtl/prga_fifo_ext.sv | 101 ++++++++++
 tb/tb_prga_fifo_ext.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prga_fifo_ext.sv
// Parametrised synchronous FIFO. It offers a registered-read or lookahead head,
// an occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module prga_fifo_ext #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned LOOKAHEAD    = 0,
  parameter int unsigned AFULL_THRES  = (1 << DEPTH_LOG2) - 1,
  parameter int unsigned AEMPTY_THRES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status decodes look only at the occupancy register.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (32'(count) >= AFULL_THRES);
  assign almost_empty = (32'(count) <= AEMPTY_THRES);

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // Storage is deliberately not reset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Holds the most recently popped word. It is the read data in registered
  // mode and the stable fallback in lookahead mode while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_ptr];
    end
  end

  generate
    if (LOOKAHEAD != 0) begin : g_lookahead
      assign dout = empty ? dout_q : mem[rd_ptr];
    end else begin : g_registered
      assign dout = dout_q;
    end
  endgenerate

  // Sticky errors; a new violation wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err) | (wr & full);
      underflow <= (underflow & ~clr_err) | (rd & empty);
    end
  end

endmodule

// File: tb/tb_prga_fifo_ext.sv
// Randomised and directed bench for prga_fifo_ext across four parameter sets
// sharing one stimulus stream, checked against a queue-style reference model.
module tb_prga_fifo_ext;

  localparam int NI = 4;
  localparam int D  [NI] = '{8, 8, 2, 32};
  localparam int LA [NI] = '{0, 1, 0, 1};
  localparam int AF [NI] = '{7, 7, 3, 31};
  localparam int AE [NI] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  logic [NI-1:0]      full_v, afull_v, empty_v, aempty_v, ovf_v, udf_v;
  logic [NI-1:0][7:0] dout_v;
  logic [3:0]         cnt0, cnt1;
  logic [1:0]         cnt2;
  logic [5:0]         cnt3;

  int checks = 0;
  int failures = 0;

  // Reference model: per-instance ring of entries plus head index and occupancy.
  logic [7:0] md [NI][32];
  int         mh [NI];
  int         mc [NI];
  logic [7:0] mdout [NI];
  bit         movf [NI];
  bit         mudf [NI];

  logic [7:0] pat [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};

  always #5 clk = ~clk;

  prga_fifo_ext #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(0), .AFULL_THRES(7), .AEMPTY_THRES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full_v[0]), .almost_full(afull_v[0]),
    .rd(rd), .dout(dout_v[0]), .empty(empty_v[0]), .almost_empty(aempty_v[0]), .count(cnt0),
    .clr_err(clr_err), .overflow(ovf_v[0]), .underflow(udf_v[0]));

  prga_fifo_ext #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(1), .AFULL_THRES(7), .AEMPTY_THRES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full_v[1]), .almost_full(afull_v[1]),
    .rd(rd), .dout(dout_v[1]), .empty(empty_v[1]), .almost_empty(aempty_v[1]), .count(cnt1),
    .clr_err(clr_err), .overflow(ovf_v[1]), .underflow(udf_v[1]));

  prga_fifo_ext #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(0), .AFULL_THRES(3), .AEMPTY_THRES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full_v[2]), .almost_full(afull_v[2]),
    .rd(rd), .dout(dout_v[2]), .empty(empty_v[2]), .almost_empty(aempty_v[2]), .count(cnt2),
    .clr_err(clr_err), .overflow(ovf_v[2]), .underflow(udf_v[2]));

  prga_fifo_ext #(.DATA_WIDTH(8), .DEPTH_LOG2(5), .LOOKAHEAD(1), .AFULL_THRES(31), .AEMPTY_THRES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full_v[3]), .almost_full(afull_v[3]),
    .rd(rd), .dout(dout_v[3]), .empty(empty_v[3]), .almost_empty(aempty_v[3]), .count(cnt3),
    .clr_err(clr_err), .overflow(ovf_v[3]), .underflow(udf_v[3]));

  function automatic int act_count(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit f, e, wa, ra;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        mc[i] = 0; mh[i] = 0; mdout[i] = 8'h00; movf[i] = 1'b0; mudf[i] = 1'b0;
      end else begin
        f  = (mc[i] == D[i]);
        e  = (mc[i] == 0);
        wa = wr && !f;
        ra = rd && !e;
        movf[i] = (movf[i] && !clr_err) || (wr && f);
        mudf[i] = (mudf[i] && !clr_err) || (rd && e);
        if (wa) md[i][(mh[i] + mc[i]) % D[i]] = din;
        if (ra) begin
          mdout[i] = md[i][mh[i]];
          mh[i] = (mh[i] + 1) % D[i];
        end
        mc[i] = mc[i] + int'(wa) - int'(ra);
      end
    end
  endtask

  task automatic compare_all();
    int exp_dout;
    for (int i = 0; i < NI; i++) begin
      if (LA[i] != 0 && mc[i] != 0) exp_dout = int'(md[i][mh[i]]);
      else                          exp_dout = int'(mdout[i]);
      chk($sformatf("u%0d_count", i), act_count(i), mc[i]);
      chk($sformatf("u%0d_full", i), int'(full_v[i]), int'(mc[i] == D[i]));
      chk($sformatf("u%0d_empty", i), int'(empty_v[i]), int'(mc[i] == 0));
      chk($sformatf("u%0d_almost_full", i), int'(afull_v[i]), int'(mc[i] >= AF[i]));
      chk($sformatf("u%0d_almost_empty", i), int'(aempty_v[i]), int'(mc[i] <= AE[i]));
      chk($sformatf("u%0d_dout", i), int'(dout_v[i]), exp_dout);
      chk($sformatf("u%0d_overflow", i), int'(ovf_v[i]), int'(movf[i]));
      chk($sformatf("u%0d_underflow", i), int'(udf_v[i]), int'(mudf[i]));
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rn);
    wr = w; rd = r; din = d; clr_err = c; rst_n = rn;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lit_reset_count", int'(cnt0), 0);
    chk("lit_reset_empty", int'(empty_v[0]), 1);
    chk("lit_reset_aempty", int'(aempty_v[0]), 1);
    chk("lit_reset_afull", int'(afull_v[0]), 0);
    chk("lit_reset_dout", int'(dout_v[0]), 0);

    // Underflow and set-beats-clear
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("lit_udf_set", int'(udf_v[0]), 1);
    chk("lit_udf_count", int'(cnt0), 0);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("lit_udf_set_wins", int'(udf_v[0]), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_udf_cleared", int'(udf_v[0]), 0);

    // Fill
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, pat[k], 1'b0, 1'b1);
      if (k == 0) begin
        chk("lit_la_empty_deassert", int'(empty_v[1]), 0);
        chk("lit_la_first_word", int'(dout_v[1]), 32'h5A);
      end
      if (k == 1) begin
        chk("lit_la_head_holds", int'(dout_v[1]), 32'h5A);
        chk("lit_d2_full", int'(full_v[2]), 1);
        chk("lit_d2_count", int'(cnt2), 2);
      end
      if (k == 5) chk("lit_afull_at6", int'(afull_v[0]), 0);
      if (k == 6) chk("lit_afull_at7", int'(afull_v[0]), 1);
    end
    chk("lit_full", int'(full_v[0]), 1);
    chk("lit_full_count", int'(cnt0), 8);

    // Ninth write is rejected
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    chk("lit_ovf_set", int'(ovf_v[0]), 1);
    chk("lit_ovf_count", int'(cnt0), 8);

    // rd+wr while full: only the read is taken
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    chk("lit_rdwr_full_count", int'(cnt0), 7);
    chk("lit_rdwr_full_dout", int'(dout_v[0]), 32'h5A);
    chk("lit_la_pop_next_head", int'(dout_v[1]), 32'hF6);

    // Drain
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      chk($sformatf("lit_drain_%0d", k), int'(dout_v[0]), int'(pat[k]));
    end
    chk("lit_drained_empty", int'(empty_v[0]), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_ovf_cleared", int'(ovf_v[0]), 0);

    // rd+wr while empty: only the write is taken
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("lit_rdwr_empty_count", int'(cnt0), 1);
    chk("lit_rdwr_empty_udf", int'(udf_v[0]), 1);

    // Hold count at 4 with simultaneous rd+wr across pointer wrap
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
    chk("lit_steady_count", int'(cnt0), 4);

    // Reset mid-stream with requests present
    step(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    chk("lit_pre_reset_count", int'(cnt0), 5);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("lit_mid_reset_count", int'(cnt0), 0);
    chk("lit_mid_reset_empty", int'(empty_v[0]), 1);
    chk("lit_mid_reset_dout", int'(dout_v[0]), 0);
    chk("lit_mid_reset_udf", int'(udf_v[0]), 0);
    chk("lit_mid_reset_ovf", int'(ovf_v[0]), 0);
    step(1'b1, 1'b0, 8'hC4, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("lit_post_reset_read", int'(dout_v[0]), 32'hC4);

    // Deep instance fill: full exactly at 32
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 33; k++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
      if (k == 1) chk("lit_d32_aempty_at2", int'(aempty_v[3]), 1);
      if (k == 2) chk("lit_d32_aempty_at3", int'(aempty_v[3]), 0);
      if (k == 30) chk("lit_d32_full_at31", int'(full_v[3]), 0);
      if (k == 31) begin
        chk("lit_d32_full_at32", int'(full_v[3]), 1);
        chk("lit_d32_count", int'(cnt3), 32);
      end
    end

    // Random traffic with shifting write/read bias
    for (int n = 0; n < 3000; n++) begin
      int wb, rb;
      wb = ((n / 250) % 3 == 0) ? 80 : (((n / 250) % 3 == 1) ? 30 : 55);
      rb = 100 - wb;
      step(1'($urandom_range(0, 99) < wb), 1'($urandom_range(0, 99) < rb),
           8'($urandom), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 299) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
